// File: rtl/adder_seq_pkg.sv
// Shared constants, state encoding and index sizing for the byte-serial add sequencer.
package adder_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte index width; a one-byte sequencer still carries a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned nbytes);
    return (nbytes <= 1) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/select_adder8.sv
// 8-bit carry-select adder: rippled low nibble, precomputed high nibble for both carries.
module select_adder8 (
  output logic [7:0] s,
  output logic       co,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  always_comb begin
    lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
    hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    s   = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    co  = lo[4] ? hi1[4] : hi0[4];
  end

endmodule

// File: rtl/adder8_sequencer.sv
// Byte-serial multi-precision adder driving one select_adder8, LSB byte first.
// Optional subtract mode (A-B) is enabled by defining ADDSEQ_SUB_EN.
module adder8_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BYTE_W*NBYTES-1:0]   a,
  input  logic [BYTE_W*NBYTES-1:0]   b,
  input  logic                       ci,
`ifdef ADDSEQ_SUB_EN
  input  logic                       sub,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [BYTE_W*NBYTES-1:0]   sum,
  output logic                       co
);

  localparam int unsigned W  = BYTE_W * NBYTES;
  localparam int unsigned IW = idx_width(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    result;
  logic            co_reg;
  logic            sub_reg;

  logic [BYTE_W-1:0] add_a;
  logic [BYTE_W-1:0] add_b;
  logic [BYTE_W-1:0] add_s;
  logic              add_co;
  logic              sub_now;
  logic              carry_init;

`ifdef ADDSEQ_SUB_EN
  assign sub_now = sub;
`else
  assign sub_now = 1'b0;
`endif

  assign carry_init = sub_now | ci;

  always_comb begin
    add_a = a_reg[idx*BYTE_W +: BYTE_W];
    add_b = b_reg[idx*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_reg}};
  end

  select_adder8 u_add (
    .s  (add_s),
    .co (add_co),
    .a  (add_a),
    .b  (add_b),
    .ci (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      result  <= '0;
      co_reg  <= 1'b0;
      sub_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub_now;
            carry   <= carry_init;
            idx     <= '0;
            result  <= '0;
            co_reg  <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          result[idx*BYTE_W +: BYTE_W] <= add_s;
          carry <= add_co;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            // Latch the final carry alongside the register so co is valid during DONE.
            co_reg <= add_co;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign sum  = result;
  assign co   = co_reg;

endmodule

// File: tb/tb_adder8_sequencer.sv
// Directed bench for adder8_sequencer with NBYTES=4; subtract cases need ADDSEQ_SUB_EN.
module tb_adder8_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ci = 1'b0;
  logic        sub = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        co;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  adder8_sequencer #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
`ifdef ADDSEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and check busy/done timing and final result.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic civ, input logic subv,
                       input logic [31:0] exp_sum, input logic exp_co);
    @(negedge clk);
    a = av; b = bv; ci = civ; sub = subv; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_accept"}, {31'b0, busy}, 32'd1);
    chk({tag, "_sum_cleared"}, sum, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("%s_done_t%0d", tag, k), {31'b0, done}, {31'b0, (k == 4)});
    end
    chk({tag, "_sum"}, sum, exp_sum);
    chk({tag, "_co"}, {31'b0, co}, {31'b0, exp_co});
    tick();
    chk({tag, "_done_drop"}, {31'b0, done}, 32'd0);
    chk({tag, "_busy_drop"}, {31'b0, busy}, 32'd0);
    chk({tag, "_sum_hold"}, sum, exp_sum);
  endtask

  initial begin
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_co", {31'b0, co}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
    do_op("full_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1);

    // Request arriving mid-operation must be dropped, not queued.
    @(negedge clk);
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; ci = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; ci = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy_t3", {31'b0, busy}, 32'd1);
    chk("ign_done_t3", {31'b0, done}, 32'd0);
    tick();
    chk("ign_done_t4", {31'b0, done}, 32'd1);
    chk("ign_busy_t4", {31'b0, busy}, 32'd1);
    chk("ign_sum", sum, 32'h1010_1010);
    chk("ign_co", {31'b0, co}, 32'd0);
    tick();
    tick();
    chk("ign_no_queue", {31'b0, busy}, 32'd0);
    chk("ign_sum_hold", sum, 32'h1010_1010);

    // Asynchronous reset during the third RUN cycle.
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h1111_1111; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_partial_sum", sum, 32'h0000_2222);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_sum", sum, 32'd0);
    chk("mid_rst_co", {31'b0, co}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);

`ifdef ADDSEQ_SUB_EN
    do_op("sub_borrow", 32'd5, 32'd10, 1'b0, 1'b1, 32'hFFFF_FFFB, 1'b0);
    do_op("sub_noborrow", 32'd10, 32'd5, 1'b0, 1'b1, 32'd5, 1'b1);
`endif

    // start held high: accepts every 6 cycles.
    @(negedge clk);
    a = 32'd100; b = 32'd200; ci = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    a = 32'd127; b = 32'd127; ci = 1'b1;
    tick(); tick(); tick(); tick();
    chk("b2b_done1", {31'b0, done}, 32'd1);
    chk("b2b_sum1", sum, 32'd300);
    chk("b2b_co1", {31'b0, co}, 32'd0);
    tick();
    chk("b2b_idle_gap", {31'b0, busy}, 32'd0);
    tick();
    chk("b2b_accept2", {31'b0, busy}, 32'd1);
    chk("b2b_sum_cleared", sum, 32'd0);
    tick(); tick(); tick(); tick();
    start = 1'b0;
    chk("b2b_done2", {31'b0, done}, 32'd1);
    chk("b2b_sum2", sum, 32'd255);
    chk("b2b_co2", {31'b0, co}, 32'd0);
    tick();
    tick();
    chk("b2b_stop", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
